// File: rtl/bcd_pkg.sv
// Shared types and decimal constants for the serial packed-BCD ALU.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } bcd_state_e;

    localparam bcd_digit_t  BCD_MAX  = 4'd9;
    localparam bcd_digit_t  BCD_ADJ  = 4'd6;
    localparam int unsigned BCD_BASE = 10;

endpackage

// File: rtl/bcd_digit_alu.sv
// Single-digit BCD add/subtract with carry/borrow; time-multiplexed by the top.
// Optional BCD_CHECK_EN adds a flag for operand digits above 9.
module bcd_digit_alu
    import bcd_pkg::*;
(
    input  bcd_digit_t a,
    input  bcd_digit_t b,
    input  logic       cin,
    input  logic       sub,
    output bcd_digit_t digit,
    output logic       cout
`ifdef BCD_CHECK_EN
    ,
    output logic       invalid
`endif
);

    logic [4:0]        w_sum;
    logic signed [5:0] w_diff;

    assign w_sum  = {1'b0, a} + {1'b0, b} + {4'b0, cin};
    assign w_diff = $signed({2'b0, a}) - $signed({2'b0, b}) - $signed({5'b0, cin});

    // Only the low nibble of the adjusted value is kept, so 4-bit wrap is exact.
    always_comb begin
        digit = w_sum[3:0];
        cout  = 1'b0;
        if (sub) begin
            if (w_diff < 0) begin
                digit = w_diff[3:0] + 4'(BCD_BASE);
                cout  = 1'b1;
            end else begin
                digit = w_diff[3:0];
            end
        end else if (w_sum > {1'b0, BCD_MAX}) begin
            digit = w_sum[3:0] + BCD_ADJ;
            cout  = 1'b1;
        end
    end

`ifdef BCD_CHECK_EN
    assign invalid = (a > BCD_MAX) || (b > BCD_MAX);
`endif

endmodule

// File: rtl/bcd_serial_alu.sv
// Multi-digit packed-BCD add/subtract, one digit per clock, LSD first.
// Optional BCD_CHECK_EN adds out_invalid reporting non-BCD operand digits.
module bcd_serial_alu
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [4*DIGITS-1:0] in_a,
    input  logic [4*DIGITS-1:0] in_b,
    input  logic                in_sub,
    input  logic                in_cin,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*DIGITS-1:0] out_res,
    output logic                out_carry,
    output logic                out_zero
`ifdef BCD_CHECK_EN
    ,
    output logic                out_invalid
`endif
);

    localparam int unsigned IDX_W = $clog2(DIGITS) + 1;
    localparam int unsigned W     = 4 * DIGITS;

    bcd_state_e       r_state;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic             r_sub;
    logic             r_carry;
    logic [IDX_W-1:0] r_idx;
    logic [W-1:0]     r_res;
    logic             r_zero;
    logic             r_in_ready;
    logic             r_out_valid;

    bcd_digit_t       w_a_dig;
    bcd_digit_t       w_b_dig;
    bcd_digit_t       w_digit;
    logic             w_cout;
    logic [W-1:0]     w_res_next;
    logic             w_last;

    assign w_a_dig = r_a[4*r_idx +: 4];
    assign w_b_dig = r_b[4*r_idx +: 4];
    assign w_last  = (r_idx == IDX_W'(DIGITS - 1));

`ifdef BCD_CHECK_EN
    logic w_dig_invalid;
    logic r_invalid;
`endif

    bcd_digit_alu u_digit_alu (
        .a       (w_a_dig),
        .b       (w_b_dig),
        .cin     (r_carry),
        .sub     (r_sub),
        .digit   (w_digit),
        .cout    (w_cout)
`ifdef BCD_CHECK_EN
        ,
        .invalid (w_dig_invalid)
`endif
    );

    always_comb begin
        w_res_next = r_res;
        w_res_next[4*r_idx +: 4] = w_digit;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_sub       <= 1'b0;
            r_carry     <= 1'b0;
            r_idx       <= '0;
            r_res       <= '0;
            r_zero      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
`ifdef BCD_CHECK_EN
            r_invalid   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_a        <= in_a;
                        r_b        <= in_b;
                        r_sub      <= in_sub;
                        r_carry    <= in_cin;
                        r_idx      <= '0;
                        r_res      <= '0;
                        r_zero     <= 1'b0;
                        r_in_ready <= 1'b0;
                        r_state    <= BUSY;
`ifdef BCD_CHECK_EN
                        r_invalid  <= 1'b0;
`endif
                    end
                end
                BUSY: begin
                    r_res   <= w_res_next;
                    r_carry <= w_cout;
                    r_idx   <= r_idx + IDX_W'(1);
`ifdef BCD_CHECK_EN
                    r_invalid <= r_invalid | w_dig_invalid;
`endif
                    if (w_last) begin
                        r_zero      <= (w_res_next == '0);
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    // in_ready rises only after the output handshake edge.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_res   = r_res;
    assign out_carry = r_carry;
    assign out_zero  = r_zero;
`ifdef BCD_CHECK_EN
    assign out_invalid = r_invalid;
`endif

endmodule
